// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage of the 5-stage pipeline.
//
// Owns the PC, an optional direct-mapped one-word-per-line instruction cache
// and a byte-serial miss path to the memory arbiter.
//
// Build option:
//   IF_ICACHE_EN  defined   -> cache with 2^ICACHE_IDX_W lines; hits deliver
//                              one instruction per cycle, misses fill a line.
//                 undefined -> no cache storage; every instruction takes the
//                              4-byte fetch path and is delivered straight
//                              from the fourth returned byte.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall_in[4:0]       bit0 holds PC, bit1 holds IF outputs, bits 4:2 unused
//   jump_en, jump_addr  redirect from EX (single-cycle pulse, word aligned)
//   mem_req, mem_addr   byte-read request / byte address to memory arbiter
//   mem_grant, mem_byte returned byte valid for mem_addr this cycle
//   if_pc, if_inst,     registered output into the IF/ID register
//   if_valid            (if_valid = 0 is a bubble)
//   if_stall            combinational "cannot deliver", independent of stall_in
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | PC ready; deliver on hit, otherwise launch a 4-byte fetch
// FETCH | byte-serial read in progress, cnt = bytes already received
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ICACHE_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  stall_in,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_grant,
  input  logic [7:0]  mem_byte,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        if_stall
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [1:0]  cnt;
  logic [23:0] byte_buf;
  logic [31:0] fetched_word;
  logic        last_grant;
  logic        hit;
  logic [31:0] line;
  logic        unused_bits;

  // The fourth byte is taken directly from the bus, so only three are buffered.
  assign fetched_word = {mem_byte, byte_buf};
  assign last_grant   = (state == FETCH) && mem_grant && (cnt == 2'd3) && !jump_en;

`ifdef IF_ICACHE_EN
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];
  logic [ICACHE_IDX_W-1:0] idx;
  logic [TAG_W-1:0]        tag;

  assign idx  = pc[ICACHE_IDX_W+1:2];
  assign tag  = pc[31:ICACHE_IDX_W+2];
  assign hit  = valid_q[idx] && (tag_mem[idx] == tag);
  assign line = data_mem[idx];

  // A redirect never flags a fresh miss; only an in-flight fetch stalls.
  assign if_stall = (state == FETCH) || (!jump_en && !hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (last_grant) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag/data arrays need no reset: valid_q guards every read.
  always_ff @(posedge clk) begin
    if (last_grant) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= fetched_word;
    end
  end

  assign unused_bits = ^stall_in[4:2];
`else
  assign hit  = 1'b0;
  assign line = fetched_word;

  // Without a cache the word is delivered on the 4th grant, so IDLE is the
  // delivery cycle and never reports a stall.
  assign if_stall = (state == FETCH);

  assign unused_bits = ^{stall_in[4:2], pc[ICACHE_IDX_W+1:2], line};
`endif

  always_comb begin
    state_nxt = state;
    if (jump_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (!hit) state_nxt = FETCH;
        FETCH: if (mem_grant && cnt == 2'd3) state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      cnt      <= 2'd0;
      byte_buf <= 24'd0;
      mem_req  <= 1'b0;
      mem_addr <= 32'd0;
      if_pc    <= 32'd0;
      if_inst  <= NOP;
      if_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (jump_en) begin
        // Partial bytes are simply abandoned; nothing is written to the cache.
        pc       <= jump_addr;
        cnt      <= 2'd0;
        mem_req  <= 1'b0;
        mem_addr <= jump_addr;
        if (!stall_in[1]) if_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (hit) begin
              if (!stall_in[1]) begin
                if_inst  <= line;
                if_pc    <= pc;
                if_valid <= 1'b1;
              end
              if (!stall_in[0]) pc <= pc + 32'd4;
            end else begin
              cnt      <= 2'd0;
              mem_req  <= 1'b1;
              mem_addr <= pc;
              if (!stall_in[1]) if_valid <= 1'b0;
            end
          end
          FETCH: begin
            if (!stall_in[1]) if_valid <= 1'b0;
            if (mem_grant) begin
              cnt      <= cnt + 2'd1;
              mem_addr <= pc + {30'd0, cnt} + 32'd1;
              case (cnt)
                2'd0: byte_buf[7:0]   <= mem_byte;
                2'd1: byte_buf[15:8]  <= mem_byte;
                2'd2: byte_buf[23:16] <= mem_byte;
                default: begin
                  mem_req <= 1'b0;
`ifndef IF_ICACHE_EN
                  if (!stall_in[1]) begin
                    if_inst  <= fetched_word;
                    if_pc    <= pc;
                    if_valid <= 1'b1;
                  end
                  if (!stall_in[0]) pc <= pc + 32'd4;
`endif
                end
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipeline. Sits directly upstream of the stall controller: produces `if_stall` and consumes its 5-bit stall bus.
- Owns the PC, a small direct-mapped instruction cache, and a byte-serial miss path to the memory arbiter.
- Delivers `{if_pc, if_inst, if_valid}` into the IF/ID register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- ICACHE_IDX_W, 6, index width; the cache holds 2^ICACHE_IDX_W one-word lines.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_in  in  5  stall bus from the stall controller. Bit0 holds PC; bit1 holds IF outputs; bits4:2 are ignored.
- jump_en  in  1  branch/jump redirect from EX, single-cycle pulse.
- jump_addr  in  32  redirect target, word-aligned.
- mem_req  out  1  byte-read request to the memory arbiter.
- mem_addr  out  32  byte address of the current request.
- mem_grant  in  1  `mem_byte` is valid this cycle for `mem_addr`.
- mem_byte  in  8  returned byte.
- if_pc  out  32  PC of the delivered instruction.
- if_inst  out  32  delivered instruction word.
- if_valid  out  1  `if_inst` is a real instruction (0 = bubble).
- if_stall  out  1  fetch cannot deliver this cycle. Combinational; must never depend on `stall_in`.

Behaviour:
- Reset (async assert, any state):
  - pc = RESET_PC; state = IDLE; byte cnt = 0.
  - All cache valid bits = 0.
  - Outputs: mem_req = 0, mem_addr = 0, if_pc = 0, if_inst = 32'h0000_0013 (NOP), if_valid = 0.
- Cache addressing:
  - index = pc[ICACHE_IDX_W+1:2]; tag = pc[31:ICACHE_IDX_W+2].
  - hit = valid[index] & (tag_mem[index] == tag); evaluated combinationally on the current pc.
- FSM states are IDLE and FETCH.
- IDLE, hit:
  - if_stall = 0.
  - Next edge: if_inst <= line, if_pc <= pc, if_valid <= 1, and pc <= pc+4 unless stall_in[0]. Latency: 1 cycle from PC to output.
- IDLE, miss:
  - if_stall = 1 combinationally.
  - Next edge: state <= FETCH, cnt <= 0, mem_req <= 1, mem_addr <= pc.
- FETCH:
  - if_stall = 1.
  - On each mem_grant: buf[8*cnt +: 8] <= mem_byte (little-endian), cnt <= cnt+1, mem_addr <= pc+cnt+1.
  - On the grant with cnt == 3: write buf into the line, set tag and valid, mem_req <= 0, state <= IDLE. The following cycle hits.
- mem_req stays asserted through FETCH regardless of `stall_in`; grant timing is arbiter-defined (including during mem_stall).
- IF output register update:
  - stall_in[1] = 1: if_pc, if_inst and if_valid hold.
  - Otherwise, when no hit is delivered (miss or FETCH): if_valid <= 0 (bubble).
- jump_en has priority over everything, in any state:
  - pc <= jump_addr; state <= IDLE; cnt <= 0; mem_req <= 0.
  - Partially fetched bytes are discarded with no cache write.
  - if_valid <= 0 unless stall_in[1] (then hold).
  - if_stall in that cycle = (state == FETCH); no new miss is flagged.
- pc arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- A mem_grant arriving after an abort (while in IDLE) is ignored.

Optional Feature:
- Macro: IF_ICACHE_EN.
- Defined: cache as above.
- Undefined:
  - No tag/data/valid storage; hit is constant 0.
  - Every instruction takes the 4-byte FETCH path. The assembled word goes straight to the output register on the 4th grant: if_valid <= 1 unless stall_in[1], pc <= pc+4 unless stall_in[0].
  - In this mode `if_stall` drops in the cycle after the 4th grant.

Test Plan:
- Reset:
  - Stimulus: rst pulse mid-FETCH with cnt = 2.
  - Required: immediate if_valid = 0, mem_req = 0, pc = RESET_PC, all lines invalid.
- Cold miss:
  - Stimulus: pc = 0, memory 0..3 = 13,05,00,00, grant every cycle.
  - Required: mem_addr 0,1,2,3 sequenced; if_stall high for 5 cycles; then if_inst = 32'h0000_0513, if_pc = 0, if_valid = 1.
- Hit after fill:
  - Stimulus: jump to 0 after the line at 0 is filled.
  - Required: if_valid = 1 with if_inst = 32'h0000_0513 on the next cycle, no mem_req, if_stall = 0.
- Jump mid-fetch:
  - Stimulus: jump_en with jump_addr = 32'h100 at cnt = 2.
  - Required: mem_req low next cycle, line 0 stays invalid, next mem_addr = 32'h100.
- Stall hold:
  - Stimulus: stall_in = 5'b00111 for 3 cycles on a hit stream.
  - Required: pc, if_pc, if_inst and if_valid all unchanged; stream resumes at pc+4 after release.
- Alias eviction (ICACHE_IDX_W = 6):
  - Stimulus: fetch 32'h000, then 32'h100 (same index), then 32'h000.
  - Required: three misses, third refetches 4 bytes.
